// File: rtl/lena_pkg.sv
// Shared constants and helpers for the 3x3 window generator.
// Taps are numbered row-major, so tap 8 is the newest pixel.
package lena_pkg;

    localparam int WIN_DIM            = 3;
    localparam int WIN_TAPS           = 9;
    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic int tap(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/lena_line_buffer.sv
// One image line of storage.
// The read is synchronous and read-first, so a same-address write in the same cycle returns the old word.
module lena_line_buffer import lena_pkg::*; #(
    parameter int DEPTH = 640,
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // RAM array and output register; left unreset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lena_window3x3.sv
// 3x3 neighbourhood window generator with two line buffers and a fixed two-cycle latency.
// Taps outside the image (negative column or line) are zeroed using the incoming coordinates.
module lena_window3x3 import lena_pkg::*; #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int HW        = $clog2(IMG_WIDTH),
    localparam int VW        = $clog2(IMG_HEIGHT),
    localparam int WW        = WIN_TAPS * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic [HW-1:0]         in_hcount,
    input  logic [VW-1:0]         in_vcount,
    output logic                  out_valid,
    output logic [WW-1:0]         out_win,
    output logic [HW-1:0]         out_hcount,
    output logic [VW-1:0]         out_vcount,
    output logic                  out_full
);

    logic                  valid_d1_q;
    logic [DATA_WIDTH-1:0] pix_d1_q;
    logic [HW-1:0]         h_d1_q;
    logic [VW-1:0]         v_d1_q;
    logic [DATA_WIDTH-1:0] lb0_rd_s;
    logic [DATA_WIDTH-1:0] lb1_rd_s;
    logic [DATA_WIDTH-1:0] col_s [WIN_DIM];
    logic [WW-1:0]         sr_q, sr_d;
    logic [WW-1:0]         win_q, win_d;
    logic                  full_q, full_d;
    logic                  out_valid_q;
    logic [HW-1:0]         hc_q;
    logic [VW-1:0]         vc_q;

    // lb0 holds line v-1; its old word is forwarded into lb1, which then holds line v-2
    lena_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb0 (
        .clk       (clk),
        .rd_en_i   (in_valid),
        .rd_addr_i (in_hcount),
        .rd_data_o (lb0_rd_s),
        .wr_en_i   (in_valid),
        .wr_addr_i (in_hcount),
        .wr_data_i (in_pixel)
    );

    lena_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
        .clk       (clk),
        .rd_en_i   (in_valid),
        .rd_addr_i (in_hcount),
        .rd_data_o (lb1_rd_s),
        .wr_en_i   (valid_d1_q),
        .wr_addr_i (h_d1_q),
        .wr_data_i (lb0_rd_s)
    );

    assign col_s[0] = lb1_rd_s;
    assign col_s[1] = lb0_rd_s;
    assign col_s[2] = pix_d1_q;

    // Stage 1: capture the accepted pixel and its coordinates
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_d1_q <= 1'b0;
            pix_d1_q   <= '0;
            h_d1_q     <= '0;
            v_d1_q     <= '0;
        end else begin
            valid_d1_q <= in_valid;
            if (in_valid) begin
                pix_d1_q <= in_pixel;
                h_d1_q   <= in_hcount;
                v_d1_q   <= in_vcount;
            end
        end
    end

    // Stage 2 next state: shift the new column in, then mask out-of-image rows and columns
    always_comb begin
        sr_d   = sr_q;
        win_d  = win_q;
        full_d = full_q;
        if (valid_d1_q) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    if (c < WIN_DIM - 1) begin
                        sr_d[tap(r, c)*DATA_WIDTH +: DATA_WIDTH] = sr_q[tap(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        sr_d[tap(r, c)*DATA_WIDTH +: DATA_WIDTH] = col_s[r];
                    end
                end
            end
            // h-2+c < 0 is evaluated as h+c < 2 to stay on unsigned counts
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    if ((int'(h_d1_q) + c < WIN_DIM - 1) || (int'(v_d1_q) + r < WIN_DIM - 1)) begin
                        win_d[tap(r, c)*DATA_WIDTH +: DATA_WIDTH] = '0;
                    end else begin
                        win_d[tap(r, c)*DATA_WIDTH +: DATA_WIDTH] = sr_d[tap(r, c)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            full_d = (int'(h_d1_q) >= WIN_DIM - 1) && (int'(v_d1_q) >= WIN_DIM - 1);
        end else begin
            sr_d   = sr_q;
            win_d  = win_q;
            full_d = full_q;
        end
    end

    // Stage 2 registers: shift register and outputs hold while the stream stalls
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q        <= '0;
            win_q       <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hc_q        <= '0;
            vc_q        <= '0;
        end else begin
            sr_q        <= sr_d;
            win_q       <= win_d;
            full_q      <= full_d;
            out_valid_q <= valid_d1_q;
            if (valid_d1_q) begin
                hc_q <= h_d1_q;
                vc_q <= v_d1_q;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_win    = win_q;
    assign out_hcount = hc_q;
    assign out_vcount = vc_q;
    assign out_full   = full_q;

endmodule
